datamem_arbiter: RTL
====================

Name: datamem_arbiter

Overview:
- Shares the single-port DataMem between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Each port issues word requests over a valid/ready handshake.
- The block grants requesters round-robin, sequences the DataMem enables, captures read data, and returns a one-cycle response pulse.
- Misaligned and out-of-range accesses are rejected without touching memory.

Parameters:
- ADDR_W, 32, width of byte addresses on every port.
- DEPTH, 1024, DataMem size in bytes; must match the DataMem instance. Legal addresses are 0..DEPTH-4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rN_req_valid  in  1  (N=0,1) request present.
- rN_req_ready  out  1  request accepted this cycle when valid&&ready.
- rN_req_addr  in  ADDR_W  byte address.
- rN_req_we  in  1  1 = write, 0 = read.
- rN_req_wdata  in  32  write data.
- rN_rsp_valid  out  1  one-cycle response pulse.
- rN_rsp_rdata  out  32  read data; 0 for writes and errors.
- rN_rsp_err  out  1  1 = misaligned or out-of-range.
- mem_addr  out  ADDR_W  to DataMem addr.
- mem_write_value  out  32  to DataMem write_value.
- mem_write_enable  out  1  to DataMem write_enable.
- mem_read_enable  out  1  to DataMem read_enable.
- mem_read_value  in  32  from DataMem read_value; registered, valid the cycle after read_enable is sampled.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, grant pointer favours port 0, all outputs 0.
- FSM states and transitions:
  - IDLE -> ACCESS when any req_valid.
  - ACCESS -> CAPTURE unconditionally.
  - CAPTURE -> IDLE unconditionally.
- rN_req_ready is combinational.
  - High only in IDLE, only for the granted port, and only while that port's valid is high.
  - Never high for both ports in the same cycle.
- Arbitration in IDLE:
  - One port valid: grant that port.
  - Both valid: grant the port not granted last.
  - The last-grant register updates on each acceptance.
- On acceptance, latch addr, we, wdata and port id.
  - mem_addr and mem_write_value drive the latched values and hold them until the next acceptance.
- ACCESS (exactly one cycle):
  - Legal write: mem_write_enable=1.
  - Legal read: mem_read_enable=1.
  - Illegal request: both enables stay 0.
  - Both enables are 0 in every other state.
- Legality: addr[1:0]==0 and addr <= DEPTH-4, with unsigned compare at full ADDR_W.
- CAPTURE: on the exiting edge, register the response for the latched port.
  - rsp_valid=1.
  - rsp_rdata = mem_read_value for a legal read, else 0.
  - rsp_err = illegal.
  - The other port's rsp outputs stay 0.
- rsp_valid and rsp_err are high for exactly one cycle, then return to 0. rsp_rdata holds its value until the next response.
- Latency: if acceptance occurs at edge E0, rsp_valid is high from E2 to E3.
  - The FSM is in IDLE during the response cycle, so the next acceptance can occur at E3.
  - Peak throughput is one access per 3 cycles.
- Requests carry no response backpressure; requesters must accept rsp_valid when it arrives.
- Requesters hold addr, we and wdata stable while valid&&!ready. Only the values present at the acceptance edge are used.
- rst_n low at any time takes effect immediately, without waiting for a clock edge:
  - state returns to IDLE and mem enables drop to 0 at once;
  - the in-flight request is dropped and no response is issued;
  - ready is 0 while reset is asserted.

Test Plan:
1. Write to DataMem and read it back on port 0:
   - Port 0 writes 0x00000000 <- 0xAABBCCDD -> mem_write_enable high for exactly 1 cycle; r0_rsp_valid 2 edges after acceptance with rdata=0, err=0.
   - Port 0 then reads 0x00000000 -> r0_rsp_rdata=0xAABBCCDD.
2. Both ports valid from reset: port 0 reads 0x4, port 1 writes 0x8 <- 0x11223344.
   - Port 0 is accepted first; port 1 is accepted 3 cycles later.
   - Repeat 4 times with both valid -> grants alternate 0,1,0,1…
   - Port 1 reads 0x8 -> 0x11223344.
3. Port 1 writes to misaligned address 0x6 -> no mem enable asserted, r1_rsp_err=1, rdata=0. A read of 0x4 is unchanged.
4. Address range boundary with DEPTH=1024:
   - Address 0x400 and 0xFFFFFFFC -> err=1.
   - Address 0x3FC, write 0xDEADBEEF then read -> 0xDEADBEEF, err=0.
5. rst_n asserted during ACCESS of a write to 0x10 <- 0x55:
   - Enables drop to 0 immediately and no rsp_valid is issued.
   - After release with a request pending, ready asserts in the first cycle.
   - A read of 0x10 returns the pre-reset contents.
6. Port 1 streams 6 back-to-back reads with port 0 idle -> accepted every 3 cycles, with responses in order and never on r0_rsp_valid.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Purpose: round-robin arbiter sharing the single-port DataMem between port 0 (LSU) and port 1 (DMA/debug).
// Latency: accept at edge E0 -> ACCESS -> CAPTURE -> rsp_valid pulse E2..E3; one access per 3 cycles.
// Backpressure: req_ready only in IDLE for the granted port; responses carry no backpressure.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rN_req_valid/ready/addr/we/wdata request handshake per port (N = 0, 1)
//   rN_rsp_valid/rdata/err           one-cycle response pulse per port
//   mem_addr/write_value/write_enable/read_enable/read_value   DataMem side
module datamem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic              r0_req_we,
    input  logic [31:0]       r0_req_wdata,
    output logic              r0_rsp_valid,
    output logic [31:0]       r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic              r1_req_we,
    input  logic [31:0]       r1_req_wdata,
    output logic              r1_rsp_valid,
    output logic [31:0]       r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_value,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [31:0]       mem_read_value
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 4);

    state_t            state, state_nxt;
    logic              last_grant;   // port granted at the most recent acceptance
    logic              grant_sel;    // port that would be granted this cycle
    logic              in_idle;
    logic              accept;
    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              legal;
    logic [31:0]       rsp_dat;

    // Contention goes to the port not served last; a lone requester always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (r0_req_valid && r1_req_valid) begin
            grant_sel = ~last_grant;
        end else if (r1_req_valid) begin
            grant_sel = 1'b1;
        end
    end

    // rst_n is folded in so ready is low for the whole time reset is held.
    assign in_idle      = (state == IDLE) && rst_n;
    assign r0_req_ready = in_idle && r0_req_valid && !grant_sel;
    assign r1_req_ready = in_idle && r1_req_valid &&  grant_sel;
    assign accept       = (r0_req_valid && r0_req_ready) || (r1_req_valid && r1_req_ready);

    assign legal = (lat_addr[1:0] == 2'b00) && (lat_addr <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enables are decoded from state so an async reset drops them immediately.
    always_comb begin
        state_nxt        = state;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req_valid || r1_req_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_write_enable = legal &&  lat_we;
                mem_read_enable  = legal && !lat_we;
                state_nxt        = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch; also the source of mem_addr / mem_write_value between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;          // so port 0 wins the first contention
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (accept) begin
            last_grant <= grant_sel;
            lat_port   <= grant_sel;
            lat_we     <= grant_sel ? r1_req_we    : r0_req_we;
            lat_addr   <= grant_sel ? r1_req_addr  : r0_req_addr;
            lat_wdata  <= grant_sel ? r1_req_wdata : r0_req_wdata;
        end
    end

    assign mem_addr        = lat_addr;
    assign mem_write_value = lat_wdata;

    // DataMem read data is valid during CAPTURE (one cycle after read_enable was sampled).
    assign rsp_dat = (legal && !lat_we) ? mem_read_value : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rsp_valid <= 1'b0;
            r0_rsp_err   <= 1'b0;
            r0_rsp_rdata <= '0;
            r1_rsp_valid <= 1'b0;
            r1_rsp_err   <= 1'b0;
            r1_rsp_rdata <= '0;
        end else begin
            r0_rsp_valid <= 1'b0;
            r0_rsp_err   <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r1_rsp_err   <= 1'b0;
            if (state == CAPTURE) begin
                if (lat_port) begin
                    r1_rsp_valid <= 1'b1;
                    r1_rsp_err   <= !legal;
                    r1_rsp_rdata <= rsp_dat;
                end else begin
                    r0_rsp_valid <= 1'b1;
                    r0_rsp_err   <= !legal;
                    r0_rsp_rdata <= rsp_dat;
                end
            end
        end
    end

endmodule
